// File: rtl/platform_manager_if.sv
// Platform manager <-> game logic / renderer bundle.
// master drives figure state and frame strobes; slave is the manager.
interface platform_manager_if #(
  parameter int IW = 3
);
  logic          tick;
  logic [1:0]    state;
  logic [9:0]    fig_x;
  logic [9:0]    fig_y;
  logic [7:0]    fig_width;
  logic [7:0]    fig_height;
  logic          fly;
  logic [3:0]    spd_y;
  logic [3:0]    advance;
  logic [IW-1:0] rd_idx;
  logic [9:0]    rd_x;
  logic [9:0]    rd_y;
  logic          hit;
  logic [9:0]    floor;
  logic [15:0]   score;
  logic          busy;

  modport master (
    output tick, state, fig_x, fig_y, fig_width, fig_height,
    output fly, spd_y, advance, rd_idx,
    input  rd_x, rd_y, hit, floor, score, busy
  );

  modport slave (
    input  tick, state, fig_x, fig_y, fig_width, fig_height,
    input  fly, spd_y, advance, rd_idx,
    output rd_x, rd_y, hit, floor, score, busy
  );
endinterface

// File: rtl/platform_manager.sv
// Jump-game platform set: init, scroll, recycle, landing check, score.
// One slot handled per cycle; hit pulses the cycle after DONE.
module platform_manager #(
  parameter int          NUM_PLAT  = 8,
  parameter int          PLAT_W    = 64,
  parameter int          PLAT_H    = 8,
  parameter int          MAP_W     = 640,
  parameter int          MAP_H     = 480,
  parameter int          SPACING   = 60,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  platform_manager_if.slave pm
);
  localparam int IW = $clog2(NUM_PLAT);
  localparam int XR = MAP_W - PLAT_W;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] INIT   = 3'd1;
  localparam logic [2:0] SCROLL = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]    fsm;
  logic [IW-1:0] i;
  logic          found;
  logic          hit_q;
  logic [9:0]    floor_q;
  logic [15:0]   score_q;
  logic [15:0]   lfsr;
  logic [9:0]    xs [NUM_PLAT];
  logic [9:0]    ys [NUM_PLAT];

  logic          fb;
  logic [9:0]    r;
  logic [9:0]    rand_x;
  logic [10:0]   ny;
  logic [10:0]   bot;
  logic [10:0]   ytop;
  logic [10:0]   fig_r;
  logic [10:0]   x_r;
  logic          match;
  logic          last;
  logic          playing;
  logic [16:0]   sum;
  logic [9:0]    y_init;

  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign r       = lfsr[9:0];
  assign rand_x  = (r < 10'(XR)) ? r : r - 10'(XR);
  assign playing = (pm.state == 2'd2);
  assign last    = (i == IW'(NUM_PLAT - 1));
  assign y_init  = 10'(MAP_H - 16 - SPACING * int'(i));

  always_comb begin
    ny    = {1'b0, ys[i]} + {7'b0, pm.advance};
    bot   = {1'b0, pm.fig_y} + {3'b0, pm.fig_height};
    ytop  = {1'b0, ys[i]} + 11'(PLAT_H) + {7'b0, pm.spd_y};
    fig_r = {1'b0, pm.fig_x} + {3'b0, pm.fig_width};
    x_r   = {1'b0, xs[i]} + 11'(PLAT_W);
    sum   = {1'b0, score_q} + {13'b0, pm.advance};
    match = !pm.fly && !found
         && ({1'b0, ys[i]} <= bot) && (bot < ytop)
         && (fig_r > {1'b0, xs[i]})
         && ({1'b0, pm.fig_x} < x_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= INIT;
      i       <= '0;
      found   <= 1'b0;
      hit_q   <= 1'b0;
      floor_q <= '0;
      score_q <= '0;
      lfsr    <= LFSR_SEED;
      for (int k = 0; k < NUM_PLAT; k++) begin
        xs[k] <= '0;
        ys[k] <= '0;
      end
    end else begin
      lfsr  <= {lfsr[14:0], fb};
      hit_q <= 1'b0;
      // leaving play abandons whatever frame work is in flight
      if (fsm != INIT && !playing) begin
        fsm <= INIT;
        i   <= '0;
      end else begin
        unique case (fsm)
          INIT: begin
            xs[i]   <= (i == '0) ? 10'(XR / 2) : rand_x;
            ys[i]   <= y_init;
            score_q <= '0;
            floor_q <= '0;
            i       <= i + 1'b1;
            if (last) fsm <= IDLE;
          end
          IDLE: begin
            if (pm.tick) begin
              fsm     <= SCROLL;
              i       <= '0;
              score_q <= sum[16] ? 16'hFFFF : sum[15:0];
            end
          end
          SCROLL: begin
            if (ny >= 11'(MAP_H)) begin
              ys[i] <= 10'(ny - 11'(MAP_H));
              xs[i] <= rand_x;
            end else begin
              ys[i] <= ny[9:0];
            end
            i <= i + 1'b1;
            if (last) begin
              fsm   <= CHECK;
              i     <= '0;
              found <= 1'b0;
            end
          end
          CHECK: begin
            if (match) begin
              found   <= 1'b1;
              floor_q <= ys[i];
            end
            i <= i + 1'b1;
            if (last) fsm <= DONE;
          end
          DONE: begin
            hit_q <= found;
            fsm   <= IDLE;
          end
          default: begin
            fsm <= INIT;
            i   <= '0;
          end
        endcase
      end
    end
  end

  assign pm.rd_x  = xs[pm.rd_idx];
  assign pm.rd_y  = ys[pm.rd_idx];
  assign pm.hit   = hit_q;
  assign pm.floor = floor_q;
  assign pm.score = score_q;
  assign pm.busy  = (fsm != IDLE);
endmodule

// File: tb/tb_platform_manager.sv
// Directed bench for platform_manager: init layout, scroll,
// landing boundaries, respawn and abort-to-init.
module tb_platform_manager;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [9:0] x, y;

  always #10 clk = ~clk;

  platform_manager_if #(.IW(3)) pm ();

  platform_manager dut (
    .clk (clk),
    .rst (rst),
    .pm  (pm)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdslot(input int idx, output logic [9:0] ox,
                        output logic [9:0] oy);
    pm.rd_idx = 3'(idx);
    #1;
    ox = pm.rd_x;
    oy = pm.rd_y;
  endtask

  task automatic frame(input string tag, input int adv,
                       input logic exp_hit, input logic [9:0] exp_floor);
    int early;
    early = 0;
    pm.advance = 4'(adv);
    pm.tick = 1'b1;
    step();
    pm.tick = 1'b0;
    repeat (16) begin
      step();
      if (pm.hit) early++;
    end
    chk({tag, "_busy17"}, 32'(pm.busy), 1);
    step();
    chk({tag, "_early"}, early, 0);
    chk({tag, "_hit18"}, 32'(pm.hit), 32'(exp_hit));
    chk({tag, "_floor"}, 32'(pm.floor), 32'(exp_floor));
    step();
    chk({tag, "_hit19"}, 32'(pm.hit), 0);
  endtask

  task automatic reinit();
    pm.state = 2'd0;
    step();
    pm.state = 2'd2;
    repeat (8) step();
  endtask

  initial begin
    int hits;
    pm.tick = 0; pm.state = 0; pm.fig_x = 300; pm.fig_y = 434;
    pm.fig_width = 32; pm.fig_height = 32; pm.fly = 1;
    pm.spd_y = 4; pm.advance = 0; pm.rd_idx = 0;
    rst = 1;
    step();
    step();
    rdslot(0, x, y);
    chk("rst_x0", 32'(x), 0);
    chk("rst_y0", 32'(y), 0);
    rdslot(5, x, y);
    chk("rst_y5", 32'(y), 0);
    chk("rst_score", 32'(pm.score), 0);
    chk("rst_busy", 32'(pm.busy), 1);
    chk("rst_hit", 32'(pm.hit), 0);
    chk("rst_floor", 32'(pm.floor), 0);

    rst = 0;
    repeat (7) step();
    chk("init_busy7", 32'(pm.busy), 1);
    step();
    pm.state = 2'd2;
    chk("init_busy8", 32'(pm.busy), 0);
    for (int k = 0; k < 8; k++) begin
      rdslot(k, x, y);
      chk($sformatf("init_y%0d", k), 32'(y), 32'(464 - 60 * k));
      chk($sformatf("init_xr%0d", k), 32'(x < 576), 1);
    end
    rdslot(0, x, y);
    chk("init_x0", 32'(x), 288);
    chk("init_score", 32'(pm.score), 0);

    frame("scroll5", 5, 1'b0, 10'd0);
    chk("scroll5_score", 32'(pm.score), 5);
    for (int k = 0; k < 8; k++) begin
      rdslot(k, x, y);
      chk($sformatf("scroll5_y%0d", k), 32'(y), 32'(469 - 60 * k));
    end

    reinit();
    rdslot(0, x, y);
    chk("reinit_y0", 32'(y), 464);
    chk("reinit_x0", 32'(x), 288);
    chk("reinit_score", 32'(pm.score), 0);

    pm.fly = 0;
    frame("land", 0, 1'b1, 10'd464);
    pm.fly = 1;
    frame("rising", 0, 1'b0, 10'd464);
    pm.fly = 0;
    pm.fig_x = 360; frame("x360", 0, 1'b0, 10'd464);
    pm.fig_x = 351; frame("x351", 0, 1'b1, 10'd464);
    pm.fig_x = 256; frame("x256", 0, 1'b0, 10'd464);
    pm.fig_x = 257; frame("x257", 0, 1'b1, 10'd464);
    pm.fig_x = 300;
    pm.fig_y = 431; frame("bot463", 0, 1'b0, 10'd464);
    pm.fig_y = 432; frame("bot464", 0, 1'b1, 10'd464);
    pm.fig_y = 443; frame("bot475", 0, 1'b1, 10'd464);
    pm.fig_y = 444; frame("bot476", 0, 1'b0, 10'd464);
    chk("land_score", 32'(pm.score), 0);

    pm.fly = 1;
    frame("adv14", 14, 1'b0, 10'd464);
    rdslot(0, x, y);
    chk("adv14_y0", 32'(y), 478);
    chk("adv14_x0", 32'(x), 288);
    frame("wrap6", 6, 1'b0, 10'd464);
    rdslot(0, x, y);
    chk("wrap_y0", 32'(y), 4);
    chk("wrap_xr", 32'(x < 576), 1);
    chk("wrap_xnew", 32'(x != 288), 1);
    rdslot(1, x, y);
    chk("wrap_y1", 32'(y), 424);
    chk("wrap_score", 32'(pm.score), 20);

    hits = 0;
    pm.advance = 5;
    pm.tick = 1;
    step();
    pm.tick = 0;
    repeat (3) begin step(); if (pm.hit) hits++; end
    pm.state = 2'd0;
    step();
    chk("abort_busy", 32'(pm.busy), 1);
    pm.tick = 1;
    pm.state = 2'd2;
    repeat (4) begin step(); if (pm.hit) hits++; end
    pm.tick = 0;
    repeat (3) begin step(); if (pm.hit) hits++; end
    chk("abort_busy_last", 32'(pm.busy), 1);
    step();
    chk("abort_idle", 32'(pm.busy), 0);
    step();
    step();
    chk("abort_idle2", 32'(pm.busy), 0);
    chk("abort_nohit", hits, 0);
    chk("abort_score", 32'(pm.score), 0);
    rdslot(0, x, y);
    chk("abort_y0", 32'(y), 464);
    chk("abort_x0", 32'(x), 288);
    rdslot(7, x, y);
    chk("abort_y7", 32'(y), 44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
